writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage; consumes memory-stage results through a valid/ready handshake.
- Selects the writeback source (ALU result, formatted load data, PC+4) and formats sub-word loads.
- Drives the register file write port (write_enable/write_addr/write_data) from registered outputs.
- Contains a halt FSM that stops retirement on an illegal writeback request, plus a retired-instruction counter.

Parameters:
- WORD_SIZE, 32, datapath width; load formatting defined for 32 only.
- COUNT_WIDTH, 16, width of retire counter.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  memory stage presents a beat
- in_ready  output  1  stage accepts the beat this cycle
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- in_alu_result  input  WORD_SIZE  ALU result
- in_load_data  input  WORD_SIZE  raw aligned memory word
- in_pc_plus4  input  WORD_SIZE  link value
- in_funct3  input  3  load type
- in_byte_off  input  2  address[1:0] of load
- halt_clear  input  1  single-cycle pulse leaving HALT
- write_enable  output  1  register file write strobe
- write_addr  output  5  register file write address
- write_data  output  WORD_SIZE  register file write data
- halted  output  1  FSM in HALT
- err_code  output  2  00 none, 01 reserved wb_sel, 10 bad funct3, 11 misaligned
- retire_count  output  COUNT_WIDTH  accepted, non-faulting beats

Behaviour:
- Reset (asynchronous): write_enable=0, write_addr=0, write_data=0, halted=0, err_code=00, retire_count=0, state=RUN.
- Handshake:
  - in_ready = (state==RUN); combinational from state only, never from in_valid.
  - A beat is accepted at a rising edge where in_valid && in_ready.
- Latency: a beat accepted at edge N drives write_enable/addr/data from just after edge N until edge N+1, so the register file samples it at edge N+1.
- write_enable:
  - Registered every cycle; high for exactly one cycle per accepted legal beat with in_reg_write=1 and in_rd!=0.
  - Otherwise write_enable=0 and write_addr/write_data hold their previous values.
- Source select: 00 in_alu_result; 10 in_pc_plus4; 01 formatted load.
- Load formatting (by in_funct3):
  - 000 LB: byte at lane in_byte_off, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at lane in_byte_off[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: whole word.
  - Lane 0 = bits[7:0] for bytes and bits[15:0] for halfwords.
- Fault checks (on accepted beats, first match wins, regardless of in_reg_write):
  - wb_sel=11 -> err 01.
  - wb_sel=01 with funct3 in {011,110,111} -> err 10.
  - LH/LHU with in_byte_off[0]=1, or LW with in_byte_off!=0 -> err 11.
- Faulting beat: no write, retire_count unchanged, state->HALT at same edge, err_code latched.
- FSM:
  - RUN -> HALT on faulting accepted beat.
  - HALT -> RUN at the edge where halt_clear=1; err_code clears to 00 at that edge.
  - halt_clear in RUN is ignored.
  - halted = (state==HALT).
- retire_count:
  - Increments by 1 per accepted legal beat, including those that do not write (in_reg_write=0 or rd=0).
  - Wraps from all-ones to 0.
- Reset mid-write: write_enable drops immediately (asynchronous); the pending write is lost.
- in_valid=0 in RUN: write_enable=0 next cycle; no state change.

Test Plan:
- Reset, then accept ALU beat rd=5, data 0x0000_1234 -> write_enable=1 one cycle after acceptance, write_addr=5, write_data=0x1234; retire_count=1.
- Loads with in_load_data=0x80FF_7F80: LB off=0 -> 0xFFFF_FF80; LBU off=0 -> 0x0000_0080; LB off=1 -> 0x0000_007F; LH off=2 -> 0xFFFF_80FF; LHU off=2 -> 0x0000_80FF; LW -> 0x80FF_7F80.
- Beat with rd=0 and in_reg_write=1, plus a beat with in_reg_write=0 -> write_enable stays 0 for both; retire_count advances by 2.
- LW with in_byte_off=2 -> no write, halted=1, err_code=11, in_ready=0. Subsequent valid beats are ignored until a halt_clear pulse, after which halted=0, err_code=00, and in_ready=1 next cycle.
- Back-to-back valid beats rd=1..4, PC+4 values 0x104..0x110 -> four consecutive write_enable cycles with matching addr/data; retire_count=4.
- Assert reset_n low while write_enable=1 -> write_enable and all outputs 0 immediately. Also preload retire_count to all-ones via 2^COUNT_WIDTH-1 beats, then one more beat -> wraps to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects and formats the writeback value, drives the register
// file write port from registers, halts on illegal requests and counts retirements.
module writeback_stage #(
  parameter int WORD_SIZE   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_reg_write,
  input  logic [4:0]             in_rd,
  input  logic [1:0]             in_wb_sel,
  input  logic [WORD_SIZE-1:0]   in_alu_result,
  input  logic [WORD_SIZE-1:0]   in_load_data,
  input  logic [WORD_SIZE-1:0]   in_pc_plus4,
  input  logic [2:0]             in_funct3,
  input  logic [1:0]             in_byte_off,
  input  logic                   halt_clear,
  output logic                   write_enable,
  output logic [4:0]             write_addr,
  output logic [WORD_SIZE-1:0]   write_data,
  output logic                   halted,
  output logic [1:0]             err_code,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]           state;
  logic [1:0]           fault_code;
  logic                 accept;
  logic                 fault;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [WORD_SIZE-1:0] load_value;
  logic [WORD_SIZE-1:0] wb_value;

  assign in_ready = (state == RUN);
  assign halted   = (state == HALT);
  assign accept   = in_valid && in_ready;
  assign fault    = (fault_code != 2'b00);

  // Fault priority: reserved select, then unknown load type, then misalignment.
  always_comb begin
    fault_code = 2'b00;
    if (in_wb_sel == 2'b11) begin
      fault_code = 2'b01;
    end else if (in_wb_sel == 2'b01) begin
      case (in_funct3)
        3'b011, 3'b110, 3'b111: fault_code = 2'b10;
        3'b001, 3'b101: if (in_byte_off[0]) fault_code = 2'b11;
        3'b010: if (in_byte_off != 2'b00) fault_code = 2'b11;
        default: ;
      endcase
    end
  end

  assign byte_lane = in_load_data[{in_byte_off, 3'b000} +: 8];
  assign half_lane = in_load_data[{in_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    case (in_funct3)
      3'b000:  load_value = {{(WORD_SIZE-8){byte_lane[7]}}, byte_lane};
      3'b100:  load_value = {{(WORD_SIZE-8){1'b0}}, byte_lane};
      3'b001:  load_value = {{(WORD_SIZE-16){half_lane[15]}}, half_lane};
      3'b101:  load_value = {{(WORD_SIZE-16){1'b0}}, half_lane};
      default: load_value = in_load_data;
    endcase
  end

  always_comb begin
    case (in_wb_sel)
      2'b01:   wb_value = load_value;
      2'b10:   wb_value = in_pc_plus4;
      default: wb_value = in_alu_result;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      err_code     <= 2'b00;
      retire_count <= '0;
    end else begin
      write_enable <= accept && !fault && in_reg_write && (in_rd != 5'd0);
      if (accept && !fault && in_reg_write && (in_rd != 5'd0)) begin
        write_addr <= in_rd;
        write_data <= wb_value;
      end
      if (accept && fault) begin
        state    <= HALT;
        err_code <= fault_code;
      end else if (accept) begin
        retire_count <= retire_count + COUNT_WIDTH'(1);
      end
      if (state == HALT && halt_clear) begin
        state    <= RUN;
        err_code <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed beats with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_load_data = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_byte_off = '0;
  logic        halt_clear = 1'b0;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        halted;
  logic [1:0]  err_code;
  logic [15:0] retire_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  writeback_stage #(.WORD_SIZE(32), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data), .in_pc_plus4(in_pc_plus4),
    .in_funct3(in_funct3), .in_byte_off(in_byte_off), .halt_clear(halt_clear),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .halted(halted), .err_code(err_code), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] model_fault(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [1:0] off);
    if (sel == 2'd3) return 2'd1;
    if (sel != 2'd1) return 2'd0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'd2;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) return 2'd3;
    if (f3 == 3'd2 && off != 0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  logic        m_halt, m_we;
  logic [1:0]  m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_halt = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else begin
      logic was_halted;
      logic [1:0] f;
      was_halted = m_halt;
      m_we = 0;
      if (in_valid && !was_halted) begin
        f = model_fault(in_wb_sel, in_funct3, in_byte_off);
        if (f != 0) begin
          m_halt = 1; m_err = f;
        end else begin
          m_cnt = m_cnt + 1;
          if (in_reg_write && in_rd != 0) begin
            m_we = 1; m_addr = in_rd;
            m_data = (in_wb_sel == 2'd0) ? in_alu_result :
                     (in_wb_sel == 2'd2) ? in_pc_plus4 :
                     model_load(in_load_data, in_funct3, in_byte_off);
          end
        end
      end
      if (was_halted && halt_clear) begin
        m_halt = 0; m_err = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_we", write_enable, m_we);
    chk("cyc_addr", write_addr, m_addr);
    chk("cyc_data", write_data, m_data);
    chk("cyc_halted", halted, m_halt);
    chk("cyc_ready", in_ready, !m_halt);
    chk("cyc_err", err_code, m_err);
    chk("cyc_count", retire_count, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
    in_valid = 0;
    halt_clear = 0;
  endtask

  task automatic beat(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                      input logic [2:0] f3, input logic [1:0] off);
    in_valid = 1; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_alu_result = alu; in_load_data = ld; in_pc_plus4 = pc;
    in_funct3 = f3; in_byte_off = off;
    step();
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp,
                      input string name);
    beat(1, 5'd7, 2'd1, 32'h0, 32'h80FF_7F80, 32'h0, f3, off);
    chk({name, "_we"}, write_enable, 1);
    chk(name, write_data, exp);
  endtask

  initial begin
    logic [15:0] base;
    #12;
    chk("reset_we", write_enable, 0);
    chk("reset_data", write_data, 0);
    chk("reset_halted", halted, 0);
    chk("reset_count", retire_count, 0);
    chk("reset_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1;
    step();

    beat(1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("alu_we", write_enable, 1);
    chk("alu_addr", write_addr, 5);
    chk("alu_data", write_data, 32'h0000_1234);
    chk("alu_count", retire_count, 1);
    step();
    chk("idle_we", write_enable, 0);
    chk("idle_hold", write_data, 32'h0000_1234);

    load(3'd0, 2'd0, 32'hFFFF_FF80, "lb0");
    load(3'd4, 2'd0, 32'h0000_0080, "lbu0");
    load(3'd0, 2'd1, 32'h0000_007F, "lb1");
    load(3'd1, 2'd2, 32'hFFFF_80FF, "lh2");
    load(3'd5, 2'd2, 32'h0000_80FF, "lhu2");
    load(3'd2, 2'd0, 32'h80FF_7F80, "lw");
    chk("load_count", retire_count, 7);

    beat(1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("rd0_we", write_enable, 0);
    beat(0, 5'd3, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("nowr_we", write_enable, 0);
    chk("nowr_data", write_data, 32'h80FF_7F80);
    chk("nowr_count", retire_count, 9);

    beat(1, 5'd9, 2'd1, 32'h0, 32'h1111_2222, 32'h0, 3'd2, 2'd2);
    chk("mis_we", write_enable, 0);
    chk("mis_halted", halted, 1);
    chk("mis_err", err_code, 2'b11);
    chk("mis_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) beat(1, 5'd4, 2'd0, 32'h55, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("halt_ignore_we", write_enable, 0);
    chk("halt_ignore_count", retire_count, 9);
    halt_clear = 1;
    step();
    chk("clear_halted", halted, 0);
    chk("clear_err", err_code, 0);
    chk("clear_ready", in_ready, 1);

    base = retire_count;
    for (int i = 1; i <= 4; i++) begin
      beat(1, 5'(i), 2'd2, 32'h0, 32'h0, 32'h100 + 32'(4 * i), 3'd0, 2'd0);
      chk("b2b_we", write_enable, 1);
      chk("b2b_addr", write_addr, i);
      chk("b2b_data", write_data, 32'h100 + 32'(4 * i));
    end
    chk("b2b_count", retire_count - base, 4);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_reg_write = $urandom_range(0, 3) != 0;
      in_rd = 5'($urandom);
      in_wb_sel = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_alu_result = $urandom;
      in_load_data = $urandom;
      in_pc_plus4 = $urandom;
      in_funct3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      in_byte_off = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      halt_clear = ($urandom_range(0, 3) == 0);
      step();
    end

    halt_clear = 1;
    step();
    beat(1, 5'd12, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("pre_rst_we", write_enable, 1);
    reset_n = 0;
    #1;
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_count", retire_count, 0);
    chk("rst_err", err_code, 0);
    chk("rst_halted", halted, 0);
    @(negedge clock);
    reset_n = 1;
    step();

    for (int i = 0; i < 65535; i++) beat(0, 5'd1, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("full_count", retire_count, 16'hFFFF);
    beat(0, 5'd1, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
    chk("wrap_count", retire_count, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
